// File: rtl/sr04_pkg.sv
// Shared types and 50 MHz default timing for the SR04 echo responder.
package sr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } sr04_state_e;

  localparam int unsigned CNT_W_DEF        = 24;
  localparam int unsigned MIN_TRIG_CYC_DEF = 500;
  localparam int unsigned BURST_CYC_DEF    = 10000;
  localparam int unsigned TIMEOUT_CYC_DEF  = 1900000;
  localparam int unsigned HOLDOFF_CYC_DEF  = 500000;

  // True when val can be held in a w-bit unsigned counter.
  function automatic bit fits_in(input longint unsigned val, input int unsigned w);
    return (w >= 64) || (val < (64'd1 << w));
  endfunction

endpackage

// File: rtl/sr04_echo_responder_if.sv
// Trig/echo link between an echo-timing detector (master) and the responder (slave).
interface sr04_echo_responder_if
  import sr04_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);
  logic             trig;
  logic [CNT_W-1:0] echo_len;
  logic             echo;
  logic             busy;
  logic             trig_err;

  modport master (output trig, output echo_len, input echo, input busy, input trig_err);
  modport slave  (input trig, input echo_len, output echo, output busy, output trig_err);
endinterface

// File: rtl/sr04_cycle_timer.sv
// Loadable down-counter shared by the burst, echo and holdoff phases.
// done is high during the last cycle of a loaded interval; the count parks at 0.
module sr04_cycle_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done = (count_q == CNT_W'(1));
endmodule

// File: rtl/sr04_echo_responder.sv
// Synthesizable SR04 ultrasonic sensor stand-in: trig in, echo of programmed width out.
// Define SR04_TRIG_SYNC_EN to pass trig through a 2-flop synchronizer (adds 2 cycles latency).
//
// state   | meaning
// IDLE    | waiting for trig rising (trig must be seen low first after a shot)
// TRIG_HI | measuring trig high time
// BURST   | fixed delay from accepted trig fall to echo rise
// ECHO    | echo high for the latched width
// HOLDOFF | dead time before a new trig is accepted
module sr04_echo_responder
  import sr04_pkg::*;
#(
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned MIN_TRIG_CYC = MIN_TRIG_CYC_DEF,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEF
) (
  input logic                  clk,
  input logic                  rst,
  sr04_echo_responder_if.slave bus
);

  if (!fits_in(64'(MIN_TRIG_CYC), CNT_W) || !fits_in(64'(BURST_CYC), CNT_W) ||
      !fits_in(64'(TIMEOUT_CYC), CNT_W) || !fits_in(64'(HOLDOFF_CYC), CNT_W)) begin : g_bad_param
    $error("sr04_echo_responder: a timing parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_TRIG_CYC);
  localparam logic [CNT_W-1:0] BST_C = CNT_W'(BURST_CYC);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] HLD_C = CNT_W'(HOLDOFF_CYC);

  logic trig_s;

`ifdef SR04_TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], bus.trig};
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = bus.trig;
`endif

  sr04_state_e      state_q, state_d;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             tmr_start;
  logic [CNT_W-1:0] tmr_load;
  logic             tmr_done;
  logic [CNT_W-1:0] len_eff;

  // Zero or an over-range width both mean "no object" and give the timeout width.
  assign len_eff = (bus.echo_len == '0 || bus.echo_len > TMO_C) ? TMO_C : bus.echo_len;

  sr04_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (tmr_start),
    .load_val (tmr_load),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      armed_q <= 1'b1;
      len_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      armed_q <= armed_d;
      len_q   <= len_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    echo_d    = echo_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    armed_d   = ~trig_s;
    len_d     = len_q;
    tcnt_d    = tcnt_q;
    tmr_start = 1'b0;
    tmr_load  = '0;

    case (state_q)
      IDLE: begin
        armed_d = armed_q | ~trig_s;
        if (trig_s && armed_q) begin
          state_d = TRIG_HI;
          tcnt_d  = CNT_W'(1);
        end
      end

      TRIG_HI: begin
        if (trig_s) begin
          if (tcnt_q < MIN_C) tcnt_d = tcnt_q + CNT_W'(1);
        end else begin
          tcnt_d = '0;
          if (tcnt_q >= MIN_C) begin
            busy_d    = 1'b1;
            len_d     = len_eff;
            tmr_start = 1'b1;
            if (BST_C == '0) begin
              state_d  = ECHO;
              echo_d   = 1'b1;
              tmr_load = len_eff;
            end else begin
              state_d  = BURST;
              tmr_load = BST_C;
            end
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end

      BURST: begin
        if (tmr_done) begin
          state_d   = ECHO;
          echo_d    = 1'b1;
          tmr_start = 1'b1;
          tmr_load  = len_q;
        end
      end

      ECHO: begin
        if (tmr_done) begin
          echo_d = 1'b0;
          if (HLD_C == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d   = HOLDOFF;
            tmr_start = 1'b1;
            tmr_load  = HLD_C;
          end
        end
      end

      HOLDOFF: begin
        if (tmr_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        echo_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = busy_q;
  assign bus.trig_err = err_q;

endmodule
